// File: rtl/apb_slave_responder.sv
// APB completer: R/W register bank, read-only transfer counter, WAIT_STATES wait cycles, error response.
// Define APB_SLAVE_PSTRB_EN to add the pstrb port and byte-masked writes.
module apb_slave_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_SLAVE_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
);

    localparam int            IW       = ADDR_WIDTH - 2;
    localparam int            SW       = DATA_WIDTH / 8;
    localparam logic [IW-1:0] CNT_IDX  = IW'(NUM_REGS - 1);
    localparam logic [IW-1:0] NREG_IDX = IW'(NUM_REGS);
    localparam logic [3:0]    WS_LOAD  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SETUP = 2'd1, ST_ACCESS = 2'd2} state_t;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_v,
                                                          input logic [DATA_WIDTH-1:0] new_v,
                                                          input logic [SW-1:0]         strb_v);
        logic [DATA_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < SW; b++) begin
            if (strb_v[b]) res[8*b +: 8] = new_v[8*b +: 8];
            else           res[8*b +: 8] = old_v[8*b +: 8];
        end
        return res;
    endfunction

    state_t                state_r, state_nxt_s, phase_s;
    logic [3:0]            wait_r, wait_nxt_s;
    logic [IW-1:0]         idx_r, live_idx_s, rsp_idx_s;
    logic                  write_r, err_r, live_err_s, rsp_write_s, rsp_err_s;
    logic [DATA_WIDTH-1:0] wdata_r, rd_data_s, xfer_cnt_r;
    logic [SW-1:0]         strb_r, strb_live_s;
    logic                  setup_s, done_s, commit_s, pready_nxt_s;
    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS-1];

`ifdef APB_SLAVE_PSTRB_EN
    assign strb_live_s = pstrb;
`else
    assign strb_live_s = {SW{1'b1}};
`endif

    assign live_idx_s = paddr[ADDR_WIDTH-1:2];
    assign live_err_s = (paddr[1:0] != 2'b00) || (live_idx_s >= NREG_IDX) || (pwrite && (live_idx_s == CNT_IDX));
    // pready is high only in the completion cycle, so it doubles as the "done" marker in ACCESS
    assign done_s     = (state_r == ST_ACCESS) && pready;
    assign setup_s    = psel && !penable && ((state_r == ST_IDLE) || done_s);
    assign commit_s   = done_s && !err_r;

    // Effective phase: a bus setup cycle is decoded live so completion can be registered in time
    always_comb begin
        phase_s = state_r;
        if (setup_s) phase_s = ST_SETUP;
        else         phase_s = state_r;
    end

    // Next-state, wait counter and completion decision
    always_comb begin
        state_nxt_s  = state_r;
        wait_nxt_s   = wait_r;
        pready_nxt_s = 1'b0;
        case (phase_s)
            ST_SETUP: begin
                state_nxt_s  = ST_ACCESS;
                wait_nxt_s   = WS_LOAD;
                pready_nxt_s = (WS_LOAD == 4'd0);
            end
            ST_ACCESS: begin
                if (pready) begin
                    state_nxt_s = ST_IDLE;
                end else if (psel && penable) begin
                    wait_nxt_s   = wait_r - 4'd1;
                    pready_nxt_s = (wait_r == 4'd1);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_IDLE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Response attributes: live bus for a zero-wait completion, captured copy otherwise
    always_comb begin
        rsp_idx_s   = idx_r;
        rsp_write_s = write_r;
        rsp_err_s   = err_r;
        if (setup_s) begin
            rsp_idx_s   = live_idx_s;
            rsp_write_s = pwrite;
            rsp_err_s   = live_err_s;
        end else begin
            rsp_idx_s   = idx_r;
            rsp_write_s = write_r;
            rsp_err_s   = err_r;
        end
    end

    // Read mux, forwarding a commit landing on the same edge
    always_comb begin
        rd_data_s = '0;
        if (rsp_idx_s == CNT_IDX) begin
            rd_data_s = xfer_cnt_r + DATA_WIDTH'(commit_s);
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (rsp_idx_s == IW'(i)) begin
                    if (commit_s && write_r && (idx_r == IW'(i))) rd_data_s = merge_bytes(regs_r[i], wdata_r, strb_r);
                    else                                          rd_data_s = regs_r[i];
                end else begin
                    rd_data_s = rd_data_s;
                end
            end
        end
    end

    // FSM state and wait counter
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r <= ST_IDLE;
            wait_r  <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            wait_r  <= wait_nxt_s;
        end
    end

    // Registered response outputs, zero outside the completion cycle
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
        end else begin
            pready  <= pready_nxt_s;
            prdata  <= (pready_nxt_s && !rsp_err_s && !rsp_write_s) ? rd_data_s : '0;
            pslverr <= pready_nxt_s && rsp_err_s;
        end
    end

    // Transfer capture in the setup cycle
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            idx_r   <= '0;
            write_r <= 1'b0;
            err_r   <= 1'b0;
            wdata_r <= '0;
            strb_r  <= '0;
        end else if (setup_s) begin
            idx_r   <= live_idx_s;
            write_r <= pwrite;
            err_r   <= live_err_s;
            wdata_r <= pwdata;
            strb_r  <= strb_live_s;
        end
    end

    // Register bank and transfer counter commit on the edge ending completion
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < NUM_REGS - 1; i++) regs_r[i] <= '0;
            xfer_cnt_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (commit_s && write_r && (idx_r == IW'(i))) regs_r[i] <= merge_bytes(regs_r[i], wdata_r, strb_r);
            end
            if (commit_s) xfer_cnt_r <= xfer_cnt_r + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: doc/apb_slave_responder.md
# apb_slave_responder

APB completer (responder) that terminates transfers issued by the APB master interface on the `apb_master` bus. It holds a bank of read/write registers plus a read-only transfer counter. It inserts a parameterised number of wait states and flags errors on illegal accesses. It is the DUT-side peer used to close the loop on `apb_master` agent sequences in block-level benches and emulation builds.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: PADDR width.
- `DATA_WIDTH`, default 32: PWDATA/PRDATA width; must be 32.
- `NUM_REGS`, default 16: register count, 2..256.
- `WAIT_STATES`, default 1: access-phase cycles with PREADY low before completion, 0..15.

Ports:
- `pclk`, in, 1: bus clock. All logic is rising-edge.
- `presetn`, in, 1: asynchronous, active-low reset.
- `psel`, in, 1: slave select.
- `penable`, in, 1: access phase marker.
- `pwrite`, in, 1: 1 = write, 0 = read.
- `paddr`, in, ADDR_WIDTH: byte address.
- `pwdata`, in, DATA_WIDTH: write data.
- `pstrb`, in, DATA_WIDTH/8: byte strobes. Present only with `APB_SLAVE_PSTRB_EN`.
- `pready`, out, 1: transfer completion.
- `prdata`, out, DATA_WIDTH: read data.
- `pslverr`, out, 1: error response.

## Operation
- Register map:
  - Word-aligned offsets 0 .. 4*(NUM_REGS-2) are R/W registers `reg[i]`, where i = paddr>>2.
  - Offset 4*(NUM_REGS-1) is `xfer_cnt`, read-only. It is a 32-bit count of completed, non-error transfers and wraps 0xFFFF_FFFF -> 0.
- Error conditions, reported in the completion cycle:
  - paddr[1:0] != 0.
  - Index >= NUM_REGS.
  - Write to `xfer_cnt`.
- On error: no register update, `xfer_cnt` not incremented, `prdata` = 0, `pslverr` = 1.
- FSM states:
  - IDLE: waits for psel=1, penable=0, then goes to SETUP.
  - SETUP: captures paddr, pwrite, pwdata, and the error decode. Loads the wait counter with WAIT_STATES. Goes to ACCESS.
  - ACCESS: decrements the counter while it is nonzero. When the counter reaches 0, pready=1 for exactly one cycle, then the FSM goes to IDLE.
- Back-to-back transfers: if psel=1 and penable=0 is seen in the completion cycle, the FSM goes directly to SETUP.
- Protocol abort: in ACCESS, if psel or penable drops before completion, the FSM returns to IDLE with no commit and no counter increment.
- Commit timing:
  - A write commits on the rising edge that ends the pready=1 cycle.
  - The `xfer_cnt` increment occurs on the same edge.
  - A read of `xfer_cnt` returns the value before that transfer's own increment.

## Timing
- Reset values:
  - pready=0, prdata=0, pslverr=0.
  - All reg[i]=0, xfer_cnt=0.
  - FSM in IDLE.
- Reset mid-transfer immediately forces the reset values; the transfer is dropped.
- pready, prdata, and pslverr are registered outputs, and are 0 in every cycle except completion.
- Latency:
  - Completion occurs WAIT_STATES+1 cycles after the setup cycle.
  - With WAIT_STATES=0, pready=1 in the first access cycle (2-cycle transfer).
- prdata and pslverr are valid only while pready=1.
- paddr, pwrite, and pwdata are sampled once, in SETUP. Changes during ACCESS are ignored.

## Configuration
- `APB_SLAVE_PSTRB_EN` defined:
  - The `pstrb` port exists.
  - A write updates only the bytes whose strobe is 1.
  - pstrb=0 on a write is a legal no-op write and still increments `xfer_cnt`.
- `APB_SLAVE_PSTRB_EN` undefined:
  - There is no `pstrb` port.
  - Writes update all 4 bytes (APB3 behaviour).

## Test plan
- Reset, then read offset 0x0 -> prdata=0x0, pslverr=0, pready high exactly WAIT_STATES+1 cycles after setup.
- Write 0xDEAD_BEEF to 0x8, then read 0x8 -> 0xDEAD_BEEF. A following read of 0x3C (NUM_REGS=16) -> 2.
- Write to 0x3C, read 0x40, read 0x5 -> each gives pslverr=1 and prdata=0. A following read of 0x3C shows the count unchanged.
- With WAIT_STATES=0, run back-to-back writes of 0x1, 0x2, 0x3 to 0x0/0x4/0x8 with no IDLE cycle between them -> all three commit, and xfer_cnt=3.
- Deassert presetn during the ACCESS phase of a write of 0x55 to 0x4 -> outputs drop to 0 asynchronously, and a later read of 0x4 returns 0.
- With `APB_SLAVE_PSTRB_EN`: write 0xFFFF_FFFF then 0x1234_5678 with pstrb=4'b0101 to 0xC -> read returns 0xFF34_FF78.
